// File: rtl/boot_load_ctrl.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and writes the
// 16-bit words into instruction memory while holding the CPU in reset.
module boot_load_ctrl #(
  parameter int unsigned MAX_WORDS = 16384,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] im_addr,
  output logic [15:0] im_wdata,
  output logic        im_debug,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [3:0] {
    StIdle, StLenHi, StLenLo, StDatHi, StDatLo, StWrite, StCheck, StDone, StError
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  chk_q, chk_d;
  logic [15:0] words_q, words_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] len_full;

  assign len_full = {len_q[15:8], rx_data};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    chk_d   = chk_q;
    words_d = words_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d = StLenHi;
          words_d = '0;
          chk_d   = '0;
        end
      end
      StLenHi: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          state_d     = StLenLo;
        end
      end
      StLenLo: begin
        if (rx_valid) begin
          len_d = len_full;
          if ({16'd0, len_full} > MAX_WORDS) begin
            state_d = StError;
          end else if (len_full == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StDatHi;
          end
        end
      end
      StDatHi: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = StDatLo;
        end
      end
      StDatLo: begin
        // Address and data are registered here so they are stable for the whole WRITE cycle.
        if (rx_valid) begin
          chk_d   = chk_q ^ rx_data;
          addr_d  = BASE_ADDR + words_q;
          wdata_d = {hi_q, rx_data};
          state_d = StWrite;
        end
      end
      StWrite: begin
        words_d = words_q + 16'd1;
        state_d = (words_d == len_q) ? StCheck : StDatHi;
      end
      StCheck: begin
        if (rx_valid) begin
          state_d = (rx_data == chk_q) ? StDone : StError;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      hi_q    <= '0;
      chk_q   <= '0;
      words_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      chk_q   <= chk_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign im_debug     = (state_q == StWrite);
  assign cpu_hold     = (state_q != StDone);
  assign done         = (state_q == StDone);
  assign err          = (state_q == StError);
  assign im_addr      = addr_q;
  assign im_wdata     = wdata_q;
  assign words_loaded = words_q;

endmodule
